// File: rtl/wps_recv_pkg.sv
// Shared video-receive definitions: FSM state encodings and default frame geometry.
package wps_recv_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
  localparam logic [1:0] ST_CAPTURE    = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  localparam int LINES_DEF        = 1080;
  localparam int PIX_PER_LINE_DEF = 80;
  localparam int LINE_CNT_W       = 11;

endpackage

// File: rtl/wps_recv_edge_det.sv
// Rising/falling edge detector: compares the live input against its registered copy.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/wps_recv.sv
// Video frame receiver: skips an offset line per frame, then streams up to PIX_PER_LINE pixels
// of each data line into a ping-pong buffer for a requested number of frames.
module wps_recv
  import wps_recv_pkg::*;
#(
  parameter int DW           = 24,
  parameter int LINES        = LINES_DEF,
  parameter int PIX_PER_LINE = PIX_PER_LINE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   to_recv_frame_num_in,
  input  logic          h_sync_in,
  input  logic          v_sync_in,
  input  logic          de_in,
  input  logic [DW-1:0] pix_data_in,
  input  logic          pingpong_wr_ready_in,
  output logic          pingpong_wr_en_out,
  output logic [DW-1:0] pingpong_wr_data_out,
  output logic          frame_done_out,
  output logic [DW-1:0] left_offset_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [31:0]   frame_cnt_out,
  output logic          overflow_out,
  output logic          short_frame_out
);

  localparam int                    PIX_W     = $clog2(PIX_PER_LINE + 1);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES + 1);
  localparam logic [PIX_W-1:0]      PIX_MAX   = PIX_W'(PIX_PER_LINE);

  logic [1:0]            state_q, state_d;
  logic [31:0]           frame_num_q, frame_cnt_q;
  logic [LINE_CNT_W-1:0] line_cnt_q;
  logic [PIX_W-1:0]      pix_cnt_q;
  logic                  active_q;
  logic                  wr_en_q, frame_done_q, done_q, overflow_q, short_q;
  logic [DW-1:0]         wr_data_q, left_offset_q;

  logic vs_rise, vs_fall, de_rise, de_fall;
  logic h_sync_unused;

  edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (v_sync_in),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  edge_det u_de_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (de_in),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  // Line timing is carried entirely by de; h_sync and the v_sync falling edge carry no extra information.
  assign h_sync_unused = h_sync_in ^ vs_fall;

  // The line/pixel index of the sample on the bus this cycle, accounting for a line starting now.
  logic [LINE_CNT_W-1:0] line_cur;
  logic [PIX_W-1:0]      pix_idx;
  logic                  in_frame, pix_ok, frame_end, last_frame, start_ok;

  assign line_cur   = de_rise ? line_cnt_q + 1'b1 : line_cnt_q;
  assign pix_idx    = de_rise ? '0 : pix_cnt_q;
  assign in_frame   = (state_q == ST_CAPTURE) && active_q;
  assign pix_ok     = in_frame && de_in && (line_cur >= LINE_CNT_W'(2)) &&
                      (line_cur <= LAST_LINE) && (pix_idx < PIX_MAX);
  assign frame_end  = in_frame && de_fall && (line_cnt_q == LAST_LINE);
  assign last_frame = (frame_cnt_q + 32'd1) == frame_num_q;
  assign start_ok   = (state_q == ST_IDLE) && start && (to_recv_frame_num_in != 32'd0);

  // NOTE: state_d takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start_ok) state_d = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vs_rise)  state_d = ST_CAPTURE;
      ST_CAPTURE:    if (frame_end && last_frame) state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      frame_num_q   <= '0;
      frame_cnt_q   <= '0;
      line_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      active_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      short_q       <= 1'b0;
      left_offset_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= 1'b0;
      wr_en_q      <= pix_ok && pingpong_wr_ready_in;
      if (pix_ok && pingpong_wr_ready_in)  wr_data_q  <= pix_data_in;
      if (pix_ok && !pingpong_wr_ready_in) overflow_q <= 1'b1;

      if (start_ok) begin
        frame_num_q <= to_recv_frame_num_in;
        frame_cnt_q <= '0;
        done_q      <= 1'b0;
        overflow_q  <= 1'b0;
        short_q     <= 1'b0;
      end

      if ((state_q == ST_WAIT_VSYNC) && vs_rise) begin
        line_cnt_q <= '0;
        pix_cnt_q  <= '0;
        active_q   <= 1'b1;
      end

      if (state_q == ST_CAPTURE) begin
        if (vs_rise) begin
          // A new v_sync while a frame is still open means the previous frame was truncated.
          if (active_q) short_q <= 1'b1;
          line_cnt_q <= '0;
          pix_cnt_q  <= '0;
          active_q   <= 1'b1;
        end else if (active_q) begin
          if (de_rise) line_cnt_q <= line_cur;
          if (de_in)   pix_cnt_q  <= (pix_idx < PIX_MAX) ? pix_idx + 1'b1 : pix_idx;
          if (de_in && (line_cur == LINE_CNT_W'(1)) && (pix_idx == '0))
            left_offset_q <= pix_data_in;
          if (frame_end) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 32'd1;
            active_q     <= 1'b0;
            if (last_frame) done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign pingpong_wr_en_out   = wr_en_q;
  assign pingpong_wr_data_out = wr_data_q;
  assign frame_done_out       = frame_done_q;
  assign left_offset_out      = left_offset_q;
  assign busy_out             = (state_q == ST_WAIT_VSYNC) || (state_q == ST_CAPTURE);
  assign done_out             = done_q;
  assign frame_cnt_out        = frame_cnt_q;
  assign overflow_out         = overflow_q;
  assign short_frame_out      = short_q;

endmodule

// File: tb/tb_wps_recv.sv
// Self-checking bench for wps_recv with LINES=4, PIX_PER_LINE=8 and randomized pixel data.
module tb_wps_recv;

  localparam int DW = 24;
  localparam int LN = 4;
  localparam int PP = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, h_sync, v_sync, de, ready;
  logic [31:0]   num;
  logic [DW-1:0] pix;
  logic          wr_en, frame_done, busy, done, overflow, short_frame;
  logic [DW-1:0] wr_data, left_offset;
  logic [31:0]   frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor-owned observations; the stimulus side only reads these.
  logic [DW-1:0] got_q[$];
  int            fd_cnt = 0;
  int            stray_wr = 0;

  // Stimulus-owned reference stream.
  logic [DW-1:0] exp_q[$];
  int            rd_idx = 0;

  always #5 clk = ~clk;

  wps_recv #(.DW(DW), .LINES(LN), .PIX_PER_LINE(PP)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .to_recv_frame_num_in (num),
    .h_sync_in            (h_sync),
    .v_sync_in            (v_sync),
    .de_in                (de),
    .pix_data_in          (pix),
    .pingpong_wr_ready_in (ready),
    .pingpong_wr_en_out   (wr_en),
    .pingpong_wr_data_out (wr_data),
    .frame_done_out       (frame_done),
    .left_offset_out      (left_offset),
    .busy_out             (busy),
    .done_out             (done),
    .frame_cnt_out        (frame_cnt),
    .overflow_out         (overflow),
    .short_frame_out      (short_frame)
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (wr_en) begin
      got_q.push_back(wr_data);
      if (!busy) stray_wr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Differences between the writes seen since the last sync point and the reference stream.
  function automatic int stream_errs();
    int errs = 0;
    int n_got = got_q.size() - rd_idx;
    if (n_got != exp_q.size()) errs++;
    for (int i = 0; i < n_got && i < exp_q.size(); i++)
      if (got_q[rd_idx + i] !== exp_q[i]) errs++;
    return errs;
  endfunction

  task automatic sync_stream();
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic [31:0] n);
    start = 1'b1; num = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_vsync();
    v_sync = 1'b1; tick(); tick();
    v_sync = 1'b0; tick(); tick();
  endtask

  // Drives one de line; the model keeps the first PP pixels of a data line that met ready high.
  task automatic send_line(input int n, input bit is_data, input int stall_at,
                           input int stall_len, input logic [DW-1:0] first_pix);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] p;
      bit            rdy;
      p   = (i == 0) ? first_pix : DW'($urandom);
      rdy = !(i >= stall_at && i < stall_at + stall_len);
      de = 1'b1; pix = p; ready = rdy;
      if (is_data && i < PP && rdy) exp_q.push_back(p);
      tick();
    end
    de = 1'b0; ready = 1'b1; pix = '0;
    tick(); tick();
  endtask

  task automatic send_frame(input int n_lines, input int long_line, input int stall_line,
                            input logic [DW-1:0] offset);
    send_vsync();
    send_line(PP, 1'b0, 99, 0, offset);
    for (int l = 0; l < n_lines; l++)
      send_line((l == long_line) ? PP + 4 : PP, 1'b1, (l == stall_line) ? 3 : 99, 3, DW'($urandom));
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 100) begin tick(); k++; end
    n_assert++;
    if (!done) begin n_fail++; $display("FAIL %s_done_timeout got done=%0b want 1", name, done); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num = '0; h_sync = 1'b0; v_sync = 1'b0;
    de = 1'b0; pix = '0; ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_assert++; if (wr_en !== 1'b0)      begin n_fail++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    n_assert++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    n_assert++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
    n_assert++; if (left_offset !== '0)  begin n_fail++; $display("FAIL rst_left_offset got %h want 0", left_offset); end
    n_assert++; if (overflow !== 1'b0 || short_frame !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b want 00", overflow, short_frame); end
    sync_stream();
  endtask

  task automatic test_zero_start();
    pulse_start(32'd0);
    tick(); tick();
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_start_busy got %b want 0", busy); end
    send_vsync();
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_start_after_vsync_busy got %b want 0", busy); end
  endtask

  task automatic test_two_frames();
    int            fd0, wr0;
    logic [DW-1:0] off2;
    fd0 = fd_cnt;
    off2 = DW'($urandom);
    pulse_start(32'd2);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_busy got %b want 1", busy); end
    send_vsync();
    wr0 = got_q.size();
    send_line(PP, 1'b0, 99, 0, 24'hABCDEF);
    n_assert++; if (got_q.size() != wr0) begin n_fail++; $display("FAIL offset_line_writes got %0d want 0", got_q.size() - wr0); end
    n_assert++; if (left_offset !== 24'hABCDEF) begin n_fail++; $display("FAIL left_offset got %h want abcdef", left_offset); end
    for (int l = 0; l < LN; l++) send_line(PP, 1'b1, 99, 0, DW'($urandom));
    n_assert++; if (frame_cnt !== 32'd1 || done !== 1'b0) begin n_fail++; $display("FAIL two_mid got cnt=%0d done=%b want 1/0", frame_cnt, done); end
    send_frame(LN, -1, -1, off2);
    wait_done("two");
    n_assert++; if (got_q.size() - rd_idx != 64) begin n_fail++; $display("FAIL two_write_count got %0d want 64", got_q.size() - rd_idx); end
    n_assert++; if (stream_errs() != 0) begin n_fail++; $display("FAIL two_stream got %0d errors want 0", stream_errs()); end
    n_assert++; if (fd_cnt - fd0 != 2) begin n_fail++; $display("FAIL two_frame_done got %0d want 2", fd_cnt - fd0); end
    n_assert++; if (frame_cnt !== 32'd2) begin n_fail++; $display("FAIL two_frame_cnt got %0d want 2", frame_cnt); end
    n_assert++; if (left_offset !== off2) begin n_fail++; $display("FAIL two_latest_offset got %h want %h", left_offset, off2); end
    tick(); tick();
    n_assert++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL two_idle got busy=%b done=%b want 0/1", busy, done); end
    n_assert++; if (overflow !== 1'b0 || short_frame !== 1'b0) begin n_fail++; $display("FAIL two_flags got %b%b want 00", overflow, short_frame); end
    sync_stream();
  endtask

  task automatic test_long_line();
    pulse_start(32'd1);
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL long_done_cleared got %b want 0", done); end
    send_frame(LN, 1, -1, DW'($urandom));
    wait_done("long");
    n_assert++; if (got_q.size() - rd_idx != 32) begin n_fail++; $display("FAIL long_write_count got %0d want 32", got_q.size() - rd_idx); end
    n_assert++; if (stream_errs() != 0) begin n_fail++; $display("FAIL long_stream got %0d errors want 0", stream_errs()); end
    sync_stream();
  endtask

  task automatic test_overflow();
    pulse_start(32'd1);
    pulse_start(32'd3);
    send_frame(LN, -1, 2, DW'($urandom));
    wait_done("ovf");
    n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag got %b want 1", overflow); end
    n_assert++; if (got_q.size() - rd_idx != 29) begin n_fail++; $display("FAIL ovf_write_count got %0d want 29", got_q.size() - rd_idx); end
    n_assert++; if (stream_errs() != 0) begin n_fail++; $display("FAIL ovf_stream got %0d errors want 0", stream_errs()); end
    n_assert++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL ovf_busy_start_ignored got cnt=%0d want 1", frame_cnt); end
    sync_stream();
  endtask

  task automatic test_short_frame();
    int fd0;
    fd0 = fd_cnt;
    pulse_start(32'd1);
    n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared_on_start got %b want 0", overflow); end
    send_frame(2, -1, -1, DW'($urandom));
    send_vsync();
    n_assert++; if (short_frame !== 1'b1) begin n_fail++; $display("FAIL short_flag got %b want 1", short_frame); end
    n_assert++; if (frame_cnt !== 32'd0 || done !== 1'b0) begin n_fail++; $display("FAIL short_cnt got cnt=%0d done=%b want 0/0", frame_cnt, done); end
    send_line(PP, 1'b0, 99, 0, DW'($urandom));
    for (int l = 0; l < LN; l++) send_line(PP, 1'b1, 99, 0, DW'($urandom));
    wait_done("short");
    n_assert++; if (frame_cnt !== 32'd1 || fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL short_recover got cnt=%0d pulses=%0d want 1/1", frame_cnt, fd_cnt - fd0); end
    n_assert++; if (stream_errs() != 0) begin n_fail++; $display("FAIL short_stream got %0d errors want 0", stream_errs()); end
    sync_stream();
  endtask

  task automatic test_reset_mid_line();
    pulse_start(32'd2);
    send_vsync();
    send_line(PP, 1'b0, 99, 0, DW'($urandom));
    for (int i = 0; i < 4; i++) begin
      de = 1'b1; pix = DW'($urandom); ready = 1'b1;
      exp_q.push_back(pix);
      tick();
    end
    de = 1'b1; pix = DW'($urandom); rst_n = 1'b0;
    tick();
    n_assert++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_en got %b want 0", wr_en); end
    n_assert++; if (busy !== 1'b0 || frame_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mid_idle got busy=%b cnt=%0d want 0/0", busy, frame_cnt); end
    rst_n = 1'b1; tick();
    de = 1'b0; pix = '0; tick();
    send_vsync();
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stays_idle got %b want 0", busy); end
    n_assert++; if (stream_errs() != 0) begin n_fail++; $display("FAIL rst_mid_stream got %0d errors want 0", stream_errs()); end
    n_assert++; if (stray_wr != 0) begin n_fail++; $display("FAIL wr_outside_capture got %0d want 0", stray_wr); end
    sync_stream();
  endtask

  initial begin
    test_reset();
    test_zero_start();
    test_two_frames();
    test_long_line();
    test_overflow();
    test_short_frame();
    test_reset_mid_line();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
